// File: rtl/fetch_if.sv
// Fetch-controller bundle: PC/branch/hazard/imem inputs in, PC control and
// pipeline flush/valid outputs back. The controller uses the slave side.
interface fetch_if;
  logic [31:0] pc_cur;
  logic        br_taken;
  logic [31:0] br_target;
  logic        hazard_stall;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] pc_next;
  logic        pc_stall;
  logic        if_valid;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic [31:0] fetch_count;

  modport slave (
    input  pc_cur, br_taken, br_target, hazard_stall, imem_ready,
    output imem_req, pc_next, pc_stall, if_valid, if_id_flush, id_ex_flush,
           fetch_count
  );

  modport master (
    output pc_cur, br_taken, br_target, hazard_stall, imem_ready,
    input  imem_req, pc_next, pc_stall, if_valid, if_id_flush, id_ex_flush,
           fetch_count
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: steers the PC around imem wait states, load-use
// stalls and taken branches, and counts delivered instructions.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic    clk,
  input logic    rst,
  fetch_if.slave bus
);

  typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_WAIT, ST_REDIRECT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pend_target;
  logic [31:0] r_fetch_count;

  logic        w_pend_load;
  logic        w_imem_req;
  logic [31:0] w_pc_next;
  logic        w_pc_stall;
  logic        w_if_valid;
  logic        w_if_id_flush;
  logic        w_id_ex_flush;
  logic [31:0] w_pc_inc;

  assign w_pc_inc = bus.pc_cur + 32'd4;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_BOOT;
      r_pend_target <= 32'h0;
      r_fetch_count <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pend_load) r_pend_target <= bus.br_target;
      if (w_if_valid)  r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_pend_load   = 1'b0;
    w_imem_req    = 1'b1;
    w_pc_next     = w_pc_inc;
    w_pc_stall    = 1'b1;
    w_if_valid    = 1'b0;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;

    if (rst) begin
      // Reset drops any pending wait or redirect and squashes the pipe.
      w_state_nxt   = ST_BOOT;
      w_imem_req    = 1'b0;
      w_pc_next     = RESET_PC;
      w_pc_stall    = 1'b0;
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
    end else begin
      case (r_state)
        ST_BOOT: begin
          w_imem_req  = 1'b0;
          w_pc_next   = RESET_PC;
          w_pc_stall  = 1'b0;
          w_state_nxt = ST_FETCH;
        end
        ST_FETCH, ST_WAIT: begin
          if (bus.br_taken) begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
            if (bus.imem_ready) begin
              w_pc_next   = bus.br_target;
              w_pc_stall  = 1'b0;
              w_state_nxt = ST_FETCH;
            end else begin
              w_pend_load = 1'b1;
              w_state_nxt = ST_REDIRECT;
            end
          end else if (!bus.imem_ready) begin
            w_state_nxt = ST_WAIT;
          end else if (bus.hazard_stall) begin
            w_id_ex_flush = 1'b1;
            w_state_nxt   = ST_FETCH;
          end else begin
            w_pc_stall  = 1'b0;
            w_if_valid  = 1'b1;
            w_state_nxt = ST_FETCH;
          end
        end
        ST_REDIRECT: begin
          // The word arriving here belongs to the squashed path; newest branch wins.
          if (bus.br_taken) begin
            w_pend_load   = 1'b1;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
          end
          if (bus.imem_ready) begin
            w_pc_next   = bus.br_taken ? bus.br_target : r_pend_target;
            w_pc_stall  = 1'b0;
            w_state_nxt = ST_FETCH;
          end
        end
        default: w_state_nxt = ST_BOOT;
      endcase
    end
  end

  assign bus.imem_req    = w_imem_req;
  assign bus.pc_next     = w_pc_next;
  assign bus.pc_stall    = w_pc_stall;
  assign bus.if_valid    = w_if_valid;
  assign bus.if_id_flush = w_if_id_flush;
  assign bus.id_ex_flush = w_id_ex_flush;
  assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: stimulus pushes hand-computed expectations
// into a queue, a negedge monitor pops and compares the DUT outputs.
module tb_fetch_ctrl;

  typedef struct packed {
    logic        imem_req;
    logic [31:0] pc_next;
    logic        pc_stall;
    logic        if_valid;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic [31:0] fetch_count;
  } resp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;
  int   step_no;
  resp_t exp_q[$];

  fetch_if bus();

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input resp_t act, input resp_t exp, input int idx);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL step%0d: got req=%b next=%h stall=%b valid=%b iff=%b ief=%b cnt=%0d, expected req=%b next=%h stall=%b valid=%b iff=%b ief=%b cnt=%0d",
               idx, act.imem_req, act.pc_next, act.pc_stall, act.if_valid,
               act.if_id_flush, act.id_ex_flush, act.fetch_count,
               exp.imem_req, exp.pc_next, exp.pc_stall, exp.if_valid,
               exp.if_id_flush, exp.id_ex_flush, exp.fetch_count);
    end
  endtask

  // Monitor: outputs are a per-cycle response, so each cycle with a pending
  // expectation is compared mid-cycle.
  initial begin
    int idx = 0;
    resp_t act, exp;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        act = '{bus.imem_req, bus.pc_next, bus.pc_stall, bus.if_valid,
                bus.if_id_flush, bus.id_ex_flush, bus.fetch_count};
        check(act, exp, idx);
        idx++;
      end
    end
  end

  task automatic step(
    input logic r, input logic [31:0] pc, input logic br, input logic [31:0] tgt,
    input logic hz, input logic rdy,
    input logic e_req, input logic [31:0] e_next, input logic e_stall,
    input logic e_valid, input logic e_iff, input logic e_ief, input logic [31:0] e_cnt
  );
    resp_t e;
    @(posedge clk);
    #1;
    rst              = r;
    bus.pc_cur       = pc;
    bus.br_taken     = br;
    bus.br_target    = tgt;
    bus.hazard_stall = hz;
    bus.imem_ready   = rdy;
    e = '{e_req, e_next, e_stall, e_valid, e_iff, e_ief, e_cnt};
    exp_q.push_back(e);
    step_no++;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    step_no  = 0;
    rst = 1'b1;
    bus.pc_cur = '0; bus.br_taken = 1'b0; bus.br_target = '0;
    bus.hazard_stall = 1'b0; bus.imem_ready = 1'b1;

    //    rst pc            br tgt           hz rdy  req next          stl vld iff ief cnt
    // Reset and boot, then three sequential fetches.
    step(1, 32'h0,        0, 32'h0,        0, 1,   0, 32'h0,         0, 0, 1, 1, 0);
    step(0, 32'h0,        0, 32'h0,        1, 1,   0, 32'h0,         0, 0, 0, 0, 0);
    step(0, 32'h0,        0, 32'h0,        0, 1,   1, 32'h4,         0, 1, 0, 0, 0);
    step(0, 32'h4,        0, 32'h0,        0, 1,   1, 32'h8,         0, 1, 0, 0, 1);
    step(0, 32'h8,        0, 32'h0,        0, 1,   1, 32'hC,         0, 1, 0, 0, 2);
    // Three imem wait cycles, then delivery.
    step(0, 32'h100,      0, 32'h0,        0, 0,   1, 32'h104,       1, 0, 0, 0, 3);
    step(0, 32'h100,      0, 32'h0,        0, 0,   1, 32'h104,       1, 0, 0, 0, 3);
    step(0, 32'h100,      0, 32'h0,        0, 0,   1, 32'h104,       1, 0, 0, 0, 3);
    step(0, 32'h100,      0, 32'h0,        0, 1,   1, 32'h104,       0, 1, 0, 0, 3);
    // Load-use hazard bubble.
    step(0, 32'h200,      0, 32'h0,        1, 1,   1, 32'h204,       1, 0, 0, 1, 4);
    step(0, 32'h200,      0, 32'h0,        0, 1,   1, 32'h204,       0, 1, 0, 0, 4);
    // Branch during WAIT, redirect completes two cycles later; hazard ignored.
    step(0, 32'h300,      0, 32'h0,        0, 0,   1, 32'h304,       1, 0, 0, 0, 5);
    step(0, 32'h300,      1, 32'h400,      0, 0,   1, 32'h304,       1, 0, 1, 1, 5);
    step(0, 32'h300,      0, 32'h0,        1, 0,   1, 32'h304,       1, 0, 0, 0, 5);
    step(0, 32'h300,      0, 32'h0,        0, 1,   1, 32'h400,       0, 0, 0, 0, 5);
    step(0, 32'h400,      0, 32'h0,        0, 1,   1, 32'h404,       0, 1, 0, 0, 5);
    // Second branch while redirect pending: newest target wins.
    step(0, 32'h404,      1, 32'h400,      0, 0,   1, 32'h408,       1, 0, 1, 1, 6);
    step(0, 32'h404,      1, 32'h800,      0, 0,   1, 32'h408,       1, 0, 1, 1, 6);
    step(0, 32'h404,      0, 32'h0,        0, 1,   1, 32'h800,       0, 0, 0, 0, 6);
    // Branch on the same cycle the redirect exits, and a direct taken branch.
    step(0, 32'h800,      1, 32'h900,      0, 0,   1, 32'h804,       1, 0, 1, 1, 6);
    step(0, 32'h800,      1, 32'hA00,      0, 1,   1, 32'hA00,       0, 0, 1, 1, 6);
    step(0, 32'hA00,      1, 32'hB00,      0, 1,   1, 32'hB00,       0, 0, 1, 1, 6);
    // PC wrap at the top of the address space.
    step(0, 32'hFFFF_FFFC,0, 32'h0,        0, 1,   1, 32'h0,         0, 1, 0, 0, 6);
    // Reset mid-WAIT clears the count and returns to BOOT.
    step(0, 32'h0,        0, 32'h0,        0, 0,   1, 32'h4,         1, 0, 0, 0, 7);
    step(1, 32'h0,        0, 32'h0,        0, 0,   0, 32'h0,         0, 0, 1, 1, 7);
    step(0, 32'h4,        0, 32'h0,        0, 1,   0, 32'h0,         0, 0, 0, 0, 0);
    // Reset mid-REDIRECT must not leave a late redirect behind.
    step(0, 32'h0,        1, 32'h500,      0, 0,   1, 32'h4,         1, 0, 1, 1, 0);
    step(1, 32'h0,        0, 32'h0,        0, 1,   0, 32'h0,         0, 0, 1, 1, 0);
    step(0, 32'h0,        0, 32'h0,        0, 1,   0, 32'h0,         0, 0, 0, 0, 0);
    step(0, 32'h0,        0, 32'h0,        0, 1,   1, 32'h4,         0, 1, 0, 0, 0);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 pc_cur  input  32  current PC register output.
REQ-005 br_taken  input  1  EX-stage branch/jump resolved taken, valid for one cycle.
REQ-006 br_target  input  32  redirect address, qualified by br_taken.
REQ-007 hazard_stall  input  1  load-use hazard from the hazard unit.
REQ-008 imem_ready  input  1  instruction memory returns the word for pc_cur this cycle.
REQ-009 imem_req  output  1  fetch request to instruction memory.
REQ-010 pc_next  output  32  drives PC IN.
REQ-011 pc_stall  output  1  drives PC STALL; 1 = PC holds.
REQ-012 if_valid  output  1  write fetched word into IF/ID.
REQ-013 if_id_flush  output  1  squash IF/ID.
REQ-014 id_ex_flush  output  1  insert bubble into ID/EX.
REQ-015 fetch_count  output  32  count of instructions delivered (if_valid cycles).

Function
REQ-016 FSM states: BOOT, FETCH, WAIT, REDIRECT; outputs are combinational from state and inputs.
REQ-017 Default outputs unless overridden: imem_req=1, pc_stall=1, if_valid=0, both flushes=0, pc_next=pc_cur+4.
REQ-018 BOOT: imem_req=0, pc_next=RESET_PC, pc_stall=0; unconditionally -> FETCH next cycle.
REQ-019 FETCH/WAIT priority, highest first: br_taken, imem_ready=0, hazard_stall, normal advance.
REQ-020 br_taken with imem_ready=1: pc_next=br_target, pc_stall=0, if_id_flush=1, id_ex_flush=1, if_valid=0 -> FETCH.
REQ-021 br_taken with imem_ready=0: latch br_target into pend_target, if_id_flush=1, id_ex_flush=1, pc_stall=1 -> REDIRECT.
REQ-022 imem_ready=0, no br_taken: pc_stall=1, if_valid=0 -> WAIT.
REQ-023 hazard_stall with imem_ready=1: pc_stall=1, if_valid=0, id_ex_flush=1 -> FETCH.
REQ-024 Normal advance: pc_next=pc_cur+4, pc_stall=0, if_valid=1, fetch_count+1 -> FETCH.
REQ-025 REDIRECT: if_valid=0 always; br_taken overwrites pend_target (newest wins) and asserts both flushes.
REQ-026 REDIRECT exit on imem_ready=1: fetched word discarded, pc_next=pend_target (or br_target if br_taken same cycle), pc_stall=0 -> FETCH.
REQ-027 pc_cur+4 is modulo 2^32; 32'hFFFFFFFC advances to 32'h00000000.
REQ-028 fetch_count wraps from 32'hFFFFFFFF to 0; never incremented when if_valid=0.
REQ-029 hazard_stall is ignored in REDIRECT and BOOT.

Reset
REQ-030 rst=1 at a rising edge: state=BOOT, pend_target=0, fetch_count=0.
REQ-031 While rst=1, outputs forced: imem_req=0, pc_next=RESET_PC, pc_stall=0, if_valid=0, if_id_flush=1, id_ex_flush=1.
REQ-032 rst asserted mid-WAIT or mid-REDIRECT abandons the pending fetch/redirect; no late redirect after reset release.

Verification
REQ-033 Reset release, imem_ready=1 always, pc_cur follows pc_next -> BOOT one cycle, PCs 0x0,0x4,0x8, fetch_count 1,2,3.
REQ-034 pc_cur=0x100, imem_ready=0 for 3 cycles then 1 -> pc_stall=1 for 3 cycles, then pc_next=0x104, if_valid=1 once.
REQ-035 pc_cur=0x200, hazard_stall=1 one cycle -> pc_stall=1, id_ex_flush=1, if_valid=0; next cycle pc_next=0x204.
REQ-036 In WAIT, br_taken with br_target=0x400, imem_ready=0; 2 cycles later imem_ready=1 -> flushes pulse once, then pc_next=0x400, if_valid=0, fetch_count unchanged.
REQ-037 In REDIRECT (target 0x400), second br_taken to 0x800 before imem_ready -> exit with pc_next=0x800.
REQ-038 pc_cur=0xFFFFFFFC normal advance -> pc_next=0x00000000; rst=1 during WAIT -> next cycle state BOOT, fetch_count=0.
